ex_stage: RTL

- Execute stage that reads the ID/EX pipeline register outputs and produces the registered EX/MEM bundle.
- Computes the ALU result, branch decision/target and store data, then forwards memory/writeback controls one stage.
- Hosts an iterative shift-add multiplier for MUL and raises a stall to freeze IF/ID and ID/EX while it runs.

---
 rtl/ex_pkg.sv | 62 ++++++
 rtl/ex_mul_iter.sv | 61 ++++++
 rtl/ex_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU/mux selects, funct3 codes,
// funct7e3 bit positions, FSM states and the MUL decode helper.
package ex_pkg;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_ITYPE  = 2'b11;

  localparam logic [1:0] SEL_A_REG  = 2'b00;
  localparam logic [1:0] SEL_A_PC   = 2'b01;
  localparam logic [1:0] SEL_A_ZERO = 2'b10;
  localparam logic [1:0] SEL_A_REG2 = 2'b11;

  localparam logic [1:0] SEL_B_REG  = 2'b00;
  localparam logic [1:0] SEL_B_IMM  = 2'b01;
  localparam logic [1:0] SEL_B_FOUR = 2'b10;
  localparam logic [1:0] SEL_B_REG2 = 2'b11;

  // Writeback select is only carried through this stage.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_RSV = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_MUL  = 3'b000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int F7E3_ALT_BIT  = 6;
  localparam int F7E3_MEXT_BIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } ex_state_e;

  typedef enum logic [1:0] {
    LOAD_BUBBLE = 2'b00,
    LOAD_ALU    = 2'b01,
    LOAD_MUL    = 2'b10
  } ex_load_e;

  function automatic logic is_mul(input logic [1:0] alu_op, input logic [6:0] funct7e3);
    return (alu_op == ALU_RTYPE) && funct7e3[F7E3_MEXT_BIT] && (funct7e3[2:0] == F3_MUL);
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, XLEN cycles,
// low XLEN bits of the product held in the accumulator once done.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  logic [XLEN-1:0] mcand_reg;
  logic [XLEN-1:0] mplier_reg;
  logic [XLEN-1:0] acc_reg;
  logic [CW-1:0]   cnt_reg;
  logic            busy_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (abort) begin
      busy_reg <= 1'b0;
    end else if (start) begin
      mcand_reg  <= op_a;
      mplier_reg <= op_b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      if (mplier_reg[0]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (cnt_reg == CNT_LAST) begin
        busy_reg <= 1'b0;
      end
    end
  end

  // done marks the final iteration cycle; acc settles at the following edge.
  assign busy    = busy_reg;
  assign done    = busy_reg && (cnt_reg == CNT_LAST);
  assign product = acc_reg;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution and an optional iterative MUL that
// stalls the front end, feeding a registered EX/MEM bundle.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            flush_in,
  input  logic            mem_re_in,
  input  logic            mem_we_in,
  input  logic            reg_file_write_in,
  input  logic [1:0]      alu_op_in,
  input  logic [1:0]      select_mux_1_in,
  input  logic [1:0]      select_mux_2_in,
  input  logic [1:0]      select_mux_4_in,
  input  logic [XLEN-1:0] reg_a_in,
  input  logic [XLEN-1:0] reg_b_in,
  input  logic [XLEN-1:0] immediate_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [6:0]      funct7e3_in,
  output logic            stall_out,
  output logic            valid_out,
  output logic            mem_re_out,
  output logic            mem_we_out,
  output logic            reg_file_write_out,
  output logic [1:0]      select_mux_4_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            branch_taken_out,
  output logic [XLEN-1:0] branch_target_out
);

  logic [XLEN-1:0] op_a, op_b, alu_res, sum, diff, mul_product;
  logic [4:0]      shamt;
  logic [2:0]      funct3;
  logic            alt_op, m_ext, is_mul_op, lt_s, lt_u, eq, taken_c;
  logic            mul_start, mul_busy, mul_done;
  logic            unused_funct_bits;
  ex_state_e       state_reg, state_next;
  ex_load_e        load_sel;

  assign funct3            = funct7e3_in[2:0];
  assign alt_op            = funct7e3_in[F7E3_ALT_BIT];
  assign m_ext             = funct7e3_in[F7E3_MEXT_BIT];
  assign is_mul_op         = is_mul(alu_op_in, funct7e3_in);
  assign unused_funct_bits = ^funct7e3_in[4:3];

  always_comb begin
    case (select_mux_1_in)
      SEL_A_PC:   op_a = pc_in;
      SEL_A_ZERO: op_a = '0;
      default:    op_a = reg_a_in;
    endcase
    case (select_mux_2_in)
      SEL_B_IMM:  op_b = immediate_in;
      SEL_B_FOUR: op_b = XLEN'(4);
      default:    op_b = reg_b_in;
    endcase
  end

  assign shamt = op_b[4:0];
  assign sum   = op_a + op_b;
  assign diff  = op_a - op_b;
  assign lt_s  = $signed(op_a) < $signed(op_b);
  assign lt_u  = op_a < op_b;
  assign eq    = op_a == op_b;

  always_comb begin
    alu_res = '0;
    taken_c = 1'b0;
    case (alu_op_in)
      ALU_ADD: alu_res = sum;
      ALU_BRANCH: begin
        alu_res = diff;
        case (funct3)
          F3_BEQ:  taken_c = eq;
          F3_BNE:  taken_c = !eq;
          F3_BLT:  taken_c = lt_s;
          F3_BGE:  taken_c = !lt_s;
          F3_BLTU: taken_c = lt_u;
          F3_BGEU: taken_c = !lt_u;
          default: taken_c = 1'b0;
        endcase
      end
      default: begin
        // M-extension ops never use the single-cycle ALU; MUL comes from the core.
        if ((alu_op_in == ALU_RTYPE) && m_ext) begin
          alu_res = '0;
        end else begin
          case (funct3)
            F3_ADD:  alu_res = ((alu_op_in == ALU_RTYPE) && alt_op) ? diff : sum;
            F3_SLL:  alu_res = op_a << shamt;
            F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            F3_XOR:  alu_res = op_a ^ op_b;
            F3_SR:   alu_res = alt_op ? $unsigned($signed(op_a) >>> shamt) : (op_a >> shamt);
            F3_OR:   alu_res = op_a | op_b;
            default: alu_res = op_a & op_b;
          endcase
        end
      end
    endcase
  end

  // Reset also gates the combinational stall so a held MUL cannot stall in reset.
  always_comb begin
    state_next = state_reg;
    stall_out  = 1'b0;
    mul_start  = 1'b0;
    load_sel   = LOAD_BUBBLE;
    if (!reset || flush_in) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (valid_in && MUL_ENABLE && is_mul_op) begin
            stall_out  = 1'b1;
            mul_start  = 1'b1;
            state_next = ST_BUSY;
          end else if (valid_in) begin
            load_sel = LOAD_ALU;
          end
        end
        ST_BUSY: begin
          stall_out = 1'b1;
          if (mul_done) begin
            state_next = ST_DONE;
          end else if (!mul_busy) begin
            state_next = ST_IDLE;
          end
        end
        ST_DONE: begin
          state_next = ST_IDLE;
          if (valid_in) begin
            load_sel = LOAD_MUL;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  generate
    if (MUL_ENABLE) begin : g_mul
      ex_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .abort   (flush_in),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out          <= 1'b0;
      mem_re_out         <= 1'b0;
      mem_we_out         <= 1'b0;
      reg_file_write_out <= 1'b0;
      select_mux_4_out   <= '0;
      alu_result_out     <= '0;
      store_data_out     <= '0;
      pc_plus4_out       <= '0;
      branch_taken_out   <= 1'b0;
      branch_target_out  <= '0;
    end else if (load_sel == LOAD_BUBBLE) begin
      valid_out          <= 1'b0;
      mem_re_out         <= 1'b0;
      mem_we_out         <= 1'b0;
      reg_file_write_out <= 1'b0;
      select_mux_4_out   <= '0;
      alu_result_out     <= '0;
      store_data_out     <= '0;
      pc_plus4_out       <= '0;
      branch_taken_out   <= 1'b0;
      branch_target_out  <= '0;
    end else begin
      valid_out          <= 1'b1;
      mem_re_out         <= mem_re_in;
      mem_we_out         <= mem_we_in;
      reg_file_write_out <= reg_file_write_in;
      select_mux_4_out   <= select_mux_4_in;
      alu_result_out     <= (load_sel == LOAD_MUL) ? mul_product : alu_res;
      store_data_out     <= reg_b_in;
      pc_plus4_out       <= pc_in + XLEN'(4);
      branch_taken_out   <= taken_c;
      branch_target_out  <= pc_in + immediate_in;
    end
  end

endmodule
